// File: rtl/accum_control_fsm.sv
// accum_control_fsm: multi-cycle fetch/decode/memory/execute control for the 16-bit accumulator datapath.
// Define CTRL_PERF_COUNTER_EN to add the CycleCount/InstrCount performance counters.
module accum_control_fsm #(
  parameter int OPCODE_W = 4,
  parameter int TIMEOUT = 255
`ifdef CTRL_PERF_COUNTER_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                MemReady,
  input  logic                BranchResult,
  input  logic                Ble,
  output logic [2:0]          ALUOp,
  output logic [1:0]          AccSrc,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                PCSource,
  output logic                AccWrite,
  output logic                Halted,
  output logic                Illegal
`ifdef CTRL_PERF_COUNTER_EN
  ,
  output logic [CNT_W-1:0]    CycleCount,
  output logic [CNT_W-1:0]    InstrCount
`endif
);
  typedef enum logic [2:0] {FETCH, DECODE, MEMRD, MEMWR, EXEC, BRANCH, JUMP, HALT} state_t;
  localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_RSUB = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_LOADI = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_LOAD = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_BEQ = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_BLE = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_JUMP = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'(15);
  state_t state, next;
  logic [TW-1:0] wait_cnt;
  logic illegal_q, set_illegal, is_alu, mem_state, timeout, take;
  assign is_alu = Opcode == OP_ADD || Opcode == OP_SUB || Opcode == OP_RSUB;
  assign mem_state = state == FETCH || state == MEMRD || state == MEMWR;
  assign timeout = TIMEOUT != 0 && mem_state && !MemReady && wait_cnt == TW'(TIMEOUT - 1);
  assign take = (Opcode == OP_BEQ && BranchResult) || (Opcode == OP_BLE && Ble);
  assign Illegal = illegal_q;
  always_comb begin
    next = state;
    set_illegal = 1'b0;
    ALUOp = 3'd0;
    AccSrc = 2'd0;
    IorD = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    IRWrite = 1'b0;
    PCWrite = 1'b0;
    PCSource = 1'b0;
    AccWrite = 1'b0;
    Halted = 1'b0;
    case (state)
      FETCH: begin
        MemRead = 1'b1;
        if (MemReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          next = DECODE;
        end
      end
      DECODE: begin
        case (Opcode)
          OP_ADD, OP_SUB, OP_RSUB, OP_LOAD: next = MEMRD;
          OP_STORE: next = MEMWR;
          OP_LOADI: next = EXEC;
          OP_BEQ, OP_BLE: next = BRANCH;
          OP_JUMP: next = JUMP;
          OP_HALT: next = HALT;
          default: begin
            next = HALT;
            set_illegal = 1'b1;
          end
        endcase
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD = 1'b1;
        if (MemReady) begin
          AccWrite = Opcode == OP_LOAD;
          AccSrc = Opcode == OP_LOAD ? 2'd1 : 2'd0;
          next = is_alu ? EXEC : FETCH;
        end
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD = 1'b1;
        if (MemReady) next = FETCH;
      end
      EXEC: begin
        AccWrite = 1'b1;
        AccSrc = Opcode == OP_LOADI ? 2'd2 : 2'd0;
        ALUOp = Opcode == OP_SUB ? 3'd1 : Opcode == OP_RSUB ? 3'd2 : 3'd0;
        next = FETCH;
      end
      BRANCH: begin
        PCWrite = take;
        PCSource = take;
        next = FETCH;
      end
      JUMP: begin
        PCWrite = 1'b1;
        PCSource = 1'b1;
        next = FETCH;
      end
      HALT: Halted = 1'b1;
    endcase
    // The timed-out access keeps its strobes for this cycle; they drop once HALT is entered.
    if (timeout) begin
      next = HALT;
      set_illegal = 1'b1;
    end
    // Reset is asynchronous, so strobes must drop the moment it rises, not at the next edge.
    if (Reset) begin
      ALUOp = 3'd0;
      AccSrc = 2'd0;
      IorD = 1'b0;
      MemRead = 1'b0;
      MemWrite = 1'b0;
      IRWrite = 1'b0;
      PCWrite = 1'b0;
      PCSource = 1'b0;
      AccWrite = 1'b0;
      Halted = 1'b0;
    end
  end
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state <= FETCH;
      wait_cnt <= '0;
      illegal_q <= 1'b0;
    end else begin
      state <= next;
      wait_cnt <= (mem_state && !MemReady) ? wait_cnt + 1'b1 : '0;
      illegal_q <= illegal_q | set_illegal;
    end
  end
`ifdef CTRL_PERF_COUNTER_EN
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      CycleCount <= '0;
      InstrCount <= '0;
    end else begin
      if (state != HALT) CycleCount <= CycleCount + 1'b1;
      if (next == FETCH && state != FETCH) InstrCount <= InstrCount + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_accum_control_fsm.sv
// tb_accum_control_fsm: randomized instruction streams checked against a per-instruction cycle trace model.
module tb_accum_control_fsm;
  localparam int TO = 4;
  logic CLK = 1'b0, Reset = 1'b1, MemReady = 1'b0, BranchResult = 1'b0, Ble = 1'b0;
  logic [3:0] Opcode = 4'd0;
  logic [2:0] ALUOp;
  logic [1:0] AccSrc;
  logic IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSource, AccWrite, Halted, Illegal;
`ifdef CTRL_PERF_COUNTER_EN
  logic [31:0] CycleCount, InstrCount;
`endif
  int checks = 0, failures = 0, cc = 0, ic = 0;
  localparam logic [13:0] IL = 14'h1, HA = 14'h2, AW = 14'h4, PS = 14'h8, PW = 14'h10;
  localparam logic [13:0] IR = 14'h20, MW = 14'h40, MR = 14'h80, IOD = 14'h100;
  wire [13:0] outv = {ALUOp, AccSrc, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSource, AccWrite, Halted, Illegal};

  accum_control_fsm #(.OPCODE_W(4), .TIMEOUT(TO)) dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .MemReady(MemReady),
    .BranchResult(BranchResult), .Ble(Ble), .ALUOp(ALUOp), .AccSrc(AccSrc),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCSource(PCSource), .AccWrite(AccWrite),
    .Halted(Halted), .Illegal(Illegal)
`ifdef CTRL_PERF_COUNTER_EN
    , .CycleCount(CycleCount), .InstrCount(InstrCount)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive MemReady, compare outputs mid-cycle, advance past the edge.
  task automatic step(input string tag, input logic mr, input logic [13:0] exp);
    MemReady = mr;
    @(negedge CLK);
    check(tag, 32'(outv), 32'(exp));
`ifdef CTRL_PERF_COUNTER_EN
    check({tag, "_cycles"}, CycleCount, 32'(cc));
    check({tag, "_instrs"}, InstrCount, 32'(ic));
`endif
    if ((exp & HA) == 14'd0) cc++;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    Reset = 1'b1;
    #1;
    check("reset_outs", 32'(outv), 32'd0);
    @(posedge CLK);
    #1;
`ifdef CTRL_PERF_COUNTER_EN
    check("reset_cycles", CycleCount, 32'd0);
    check("reset_instrs", InstrCount, 32'd0);
`endif
    Reset = 1'b0;
    cc = 0;
    ic = 0;
  endtask

  task automatic run_instr(input logic [3:0] op, input int wf, input int wm, input logic br, input logic bl);
    logic [13:0] h;
    h = (op == 4'hF) ? HA : (HA | IL);
    BranchResult = br;
    Ble = bl;
    Opcode = 4'($urandom);
    for (int i = 0; i < wf; i++) step("fetch_wait", 1'b0, MR);
    step("fetch", 1'b1, MR | IR | PW);
    Opcode = op;
    step("decode", 1'($urandom), 14'd0);
    if (op <= 4'd2 || op == 4'd4) begin
      for (int i = 0; i < wm; i++) step("memrd_wait", 1'b0, MR | IOD);
      if (op == 4'd4) step("load", 1'b1, MR | IOD | AW | (14'd1 << 9));
      else begin
        step("memrd", 1'b1, MR | IOD);
        step("exec_alu", 1'($urandom), AW | (14'(op) << 11));
      end
    end else if (op == 4'd3) step("exec_loadi", 1'($urandom), AW | (14'd2 << 9));
    else if (op == 4'd5) begin
      Opcode = 4'($urandom);
      for (int i = 0; i < wm; i++) step("memwr_wait", 1'b0, MW | IOD);
      step("memwr", 1'b1, MW | IOD);
    end else if (op == 4'd6 || op == 4'd7)
      step("branch", 1'($urandom), ((op == 4'd6 && br) || (op == 4'd7 && bl)) ? (PW | PS) : 14'd0);
    else if (op == 4'd8) begin
      Opcode = 4'($urandom);
      step("jump", 1'($urandom), PW | PS);
    end else begin
      for (int i = 0; i < 3; i++) begin
        Opcode = 4'($urandom);
        step("halt", 1'($urandom), h);
      end
      do_reset;
      return;
    end
    ic++;
  endtask

  initial begin
    do_reset;
    run_instr(4'd0, 0, 0, 1'b0, 1'b0);
    run_instr(4'd4, 0, 3, 1'b0, 1'b0);
    run_instr(4'd6, 0, 0, 1'b1, 1'b0);
    run_instr(4'd6, 0, 0, 1'b0, 1'b1);
    run_instr(4'd7, 0, 0, 1'b0, 1'b1);
    run_instr(4'd7, 1, 1, 1'b1, 1'b0);
    run_instr(4'd1, 3, 3, 1'b0, 1'b0);
    run_instr(4'd2, 1, 2, 1'b0, 1'b0);
    run_instr(4'd5, 2, 3, 1'b0, 1'b0);
    run_instr(4'hA, 0, 0, 1'b0, 1'b0);
    // Reset while a store is waiting on memory.
    step("fetch", 1'b1, MR | IR | PW);
    Opcode = 4'd5;
    step("decode", 1'b0, 14'd0);
    step("memwr_wait", 1'b0, MW | IOD);
    MemReady = 1'b0;
    do_reset;
    run_instr(4'd3, 0, 0, 1'b0, 1'b0);
    do_reset;
    for (int i = 0; i < TO; i++) step("fetch_to", 1'b0, MR);
    step("fetch_timeout", 1'($urandom), HA | IL);
    step("fetch_timeout2", 1'($urandom), HA | IL);
    do_reset;
    step("fetch", 1'b1, MR | IR | PW);
    Opcode = 4'd0;
    step("decode", 1'b0, 14'd0);
    for (int i = 0; i < TO; i++) step("memrd_to", 1'b0, MR | IOD);
    step("memrd_timeout", 1'($urandom), HA | IL);
    do_reset;
    for (int n = 0; n < 80; n++)
      run_instr(4'($urandom), int'($urandom_range(0, TO - 1)), int'($urandom_range(0, TO - 1)),
                1'($urandom), 1'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
